rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and scoreboard for the single-write-port, byte-enabled 32×32 register file. It shares the one regfile write port between the in-order pipeline writeback and a long-latency unit (divider, uncached/miss load) whose results are buffered in a small FIFO. It also tracks which registers have an outstanding long-latency write, so decode can stall on RAW/WAW hazards.

## Interface
- DEPTH, 2: long-latency result FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- pipe_we  in  4  pipeline writeback byte enables; nonzero means the pipeline writes this cycle. Always granted; no backpressure.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline write data.
- lu_issue_valid  in  1  long-latency op issued this cycle; marks its destination busy.
- lu_issue_addr  in  5  destination register of the issued op.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  result accepted when lu_valid && lu_ready.
- lu_we  in  4  byte enables of the result.
- lu_waddr  in  5  result destination.
- lu_wdata  in  32  result data.
- rf_we  out  4  regfile write byte enables.
- rf_waddr  out  5  regfile write address.
- rf_wdata  out  32  regfile write data.
- chk_addr1, chk_addr2  in  5 each  decode source registers.
- busy1, busy2  out  1 each  source register has a pending long-latency write.
- buf_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Grant priority, evaluated combinationally each cycle:
  1. pipeline if pipe_we != 0;
  2. else the FIFO head if the FIFO is not empty;
  3. else the bypassed lu result (see Configuration);
  4. else idle, with rf_we = 0.
- rf_* is a pure combinational mux of the granted source. When idle, rf_waddr and rf_wdata are driven to 0.
- FIFO:
  - push on lu_valid && lu_ready, unless the result is bypassed;
  - pop at the edge where the head is granted;
  - push and pop in the same cycle leave the count unchanged;
  - read/write pointers wrap modulo DEPTH;
  - lu_ready = (buf_cnt < DEPTH), registered-state only. No combinational path from pipe_we to lu_ready.
- Scoreboard, busy[31:1] (register 0 is never busy):
  - set at the edge where lu_issue_valid is high and lu_issue_addr != 0;
  - clear at the edge where a long-latency write to that address is granted to rf_* (FIFO drain or bypass);
  - if set and clear hit the same register in the same cycle, set wins;
  - pipeline writes never touch the scoreboard.
- busyN = busy[chk_addrN] && chk_addrN != 0, combinational.
- Upstream guarantees it never issues to an already-busy register and never lets the pipeline write a busy register. Behaviour in those cases is unspecified.
- A lu result with lu_we == 0 is still accepted and still clears the scoreboard, but asserts rf_we = 0 when granted.

## Timing
- Reset (resetn low at an edge): FIFO empty, pointers 0, busy all 0, buf_cnt 0.
  - After reset: lu_ready = 1, busy1/busy2 = 0, rf_* = 0 while inputs are idle.
  - Reset mid-operation discards buffered results and clears busy bits with no regfile write.
- Pipeline write latency: 0 cycles (same cycle to rf_*).
- FIFO path:
  - result accepted at edge N is written at cycle N+1 at the earliest;
  - it is delayed one cycle per cycle of pipe_we != 0;
  - busy clears at the edge of that write.
- A continuous pipeline writeback stream starves the FIFO. This is acceptable by design.
- Full: lu_ready = 0 while buf_cnt == DEPTH. lu_* must hold while lu_valid && !lu_ready.

## Configuration
- RF_ARB_BYPASS_EN:
  - defined: when the FIFO is empty, pipe_we == 0 and lu_valid, the result goes straight to rf_* in the same cycle (0-cycle latency), is not pushed, and clears busy at that edge;
  - undefined: every lu result passes through the FIFO (minimum 1-cycle latency), and priority step 3 is absent.

## Test plan
- Reset: drive resetn = 0 for 2 cycles with random inputs, then release -> buf_cnt = 0, lu_ready = 1, busy1 = busy2 = 0 for all chk_addr.
- Issue to r5, then lu result (r5, we = 4'hF, 0xDEADBEEF) at idle pipeline -> busy1 (chk_addr1 = 5) is 1 until the write edge. rf_* = r5/0xDEADBEEF in the same cycle with bypass, or the next cycle without it. busy is 0 afterwards.
- Hold pipe_we = 4'hF for 4 cycles while pushing 2 results (DEPTH = 2) -> buf_cnt = 2 and lu_ready = 0. The third result is held. When pipe_we drops, entries drain in order, one per cycle.
- Same-cycle: a drain of r7 coinciding with lu_issue_valid to r7 -> busy[7] remains 1.
- Byte enables: lu result we = 4'b0010 to r3 -> rf_we = 4'b0010 with the data passed unchanged. lu_issue_addr = 0 -> busy never set.
- Reset asserted with buf_cnt = 2 -> no further rf_we from the FIFO, and busy is cleared.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority over buffered long-latency results.
// Optional same-cycle bypass of long-latency results when idle: define RF_ARB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [3:0]               pipe_we,
  input  logic [4:0]               pipe_waddr,
  input  logic [31:0]              pipe_wdata,
  input  logic                     lu_issue_valid,
  input  logic [4:0]               lu_issue_addr,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [3:0]               lu_we,
  input  logic [4:0]               lu_waddr,
  input  logic [31:0]              lu_wdata,
  output logic [3:0]               rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  input  logic [4:0]               chk_addr1,
  input  logic [4:0]               chk_addr2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [$clog2(DEPTH):0]   buf_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   busy_q, busy_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]  mem_we   [DEPTH];
  logic [4:0]  mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];

  logic fifo_empty;
  logic pipe_act;
  logic grant_fifo;
  logic grant_byp;
  logic push;
  logic pop;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    // Depends only on registered occupancy so pipe_we never reaches lu_ready.
    lu_ready   = (cnt_q < CW'(DEPTH));
    pipe_act   = |pipe_we;
    grant_fifo = !pipe_act && !fifo_empty;
`ifdef RF_ARB_BYPASS_EN
    grant_byp  = !pipe_act && fifo_empty && lu_valid;
`else
    grant_byp  = 1'b0;
`endif
    push = lu_valid && lu_ready && !grant_byp;
    pop  = grant_fifo;

    rf_we    = 4'd0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pipe_act) begin
      rf_we    = pipe_we;
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else if (grant_fifo) begin
      rf_we    = mem_we[rd_ptr_q];
      rf_waddr = mem_addr[rd_ptr_q];
      rf_wdata = mem_data[rd_ptr_q];
    end else if (grant_byp) begin
      rf_we    = lu_we;
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    busy_d = busy_q;
    if (grant_fifo) busy_d[mem_addr[rd_ptr_q]] = 1'b0;
    if (grant_byp)  busy_d[lu_waddr] = 1'b0;
    // Applied after the clears so a same-cycle issue to the drained register wins.
    if (lu_issue_valid && (lu_issue_addr != 5'd0)) busy_d[lu_issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_we[wr_ptr_q]   <= lu_we;
      mem_addr[wr_ptr_q] <= lu_waddr;
      mem_data[wr_ptr_q] <= lu_wdata;
    end
  end

  assign busy1   = busy_q[chk_addr1] && (chk_addr1 != 5'd0);
  assign busy2   = busy_q[chk_addr2] && (chk_addr2 != 5'd0);
  assign buf_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue/bitmap reference model plus directed literal checks.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          resetn;
  logic [3:0]    pipe_we;
  logic [4:0]    pipe_waddr;
  logic [31:0]   pipe_wdata;
  logic          lu_issue_valid;
  logic [4:0]    lu_issue_addr;
  logic          lu_valid;
  logic          lu_ready;
  logic [3:0]    lu_we;
  logic [4:0]    lu_waddr;
  logic [31:0]   lu_wdata;
  logic [3:0]    rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [4:0]    chk_addr1;
  logic [4:0]    chk_addr2;
  logic          busy1;
  logic          busy2;
  logic [CW-1:0] buf_cnt;

  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_issue_valid(lu_issue_valid), .lu_issue_addr(lu_issue_addr),
    .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_we(lu_we), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(busy1), .busy2(busy2), .buf_cnt(buf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] data;
  } res_t;

  res_t      mq[$];
  bit [31:0] mbusy;
  bit        lu_taken;
  bit        chk_en;
  int        n_pass;
  int        n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit bypass_on();
`ifdef RF_ARB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected write port from priority rules: pipeline, oldest buffered result, bypassed result, idle.
  function automatic void model_out(output logic [3:0] we, output logic [4:0] a, output logic [31:0] d);
    we = 4'd0; a = 5'd0; d = 32'd0;
    if (pipe_we != 4'd0) begin
      we = pipe_we; a = pipe_waddr; d = pipe_wdata;
    end else if (mq.size() > 0) begin
      we = mq[0].we; a = mq[0].addr; d = mq[0].data;
    end else if (bypass_on() && lu_valid) begin
      we = lu_we; a = lu_waddr; d = lu_wdata;
    end
  endfunction

  task automatic model_step();
    bit   byp;
    bit   acc;
    res_t r;
    if (!resetn) begin
      mq.delete();
      mbusy    = '0;
      lu_taken = 1'b1;
      return;
    end
    byp = bypass_on() && pipe_we == 4'd0 && mq.size() == 0 && lu_valid;
    acc = lu_valid && mq.size() < DEPTH;
    if (pipe_we == 4'd0 && mq.size() > 0) begin
      mbusy[mq[0].addr] = 1'b0;
      void'(mq.pop_front());
    end else if (byp) begin
      mbusy[lu_waddr] = 1'b0;
    end
    if (lu_issue_valid && lu_issue_addr != 5'd0) mbusy[lu_issue_addr] = 1'b1;
    if (acc && !byp) begin
      r.we = lu_we; r.addr = lu_waddr; r.data = lu_wdata;
      mq.push_back(r);
    end
    lu_taken = acc || !lu_valid;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 4'd0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    lu_issue_valid = 1'b0; lu_issue_addr = 5'd0;
    lu_valid = 1'b0; lu_we = 4'd0; lu_waddr = 5'd0; lu_wdata = 32'd0;
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
  endtask

  task automatic rand_inputs();
    pipe_we = 4'($urandom); pipe_waddr = 5'($urandom); pipe_wdata = $urandom;
    lu_issue_valid = 1'($urandom); lu_issue_addr = 5'($urandom);
    lu_valid = 1'($urandom); lu_we = 4'($urandom); lu_waddr = 5'($urandom); lu_wdata = $urandom;
    chk_addr1 = 5'($urandom); chk_addr2 = 5'($urandom);
  endtask

  // Continuous comparison against the model on every cycle out of reset.
  always @(negedge clk) begin
    logic [3:0]  e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    if (chk_en && resetn) begin
      model_out(e_we, e_a, e_d);
      check("rf_we", 32'(rf_we), 32'(e_we));
      check("rf_waddr", 32'(rf_waddr), 32'(e_a));
      check("rf_wdata", rf_wdata, e_d);
      check("lu_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
      check("buf_cnt", 32'(buf_cnt), 32'(mq.size()));
      check("busy1", 32'(busy1), 32'(mbusy[chk_addr1] && chk_addr1 != 5'd0));
      check("busy2", 32'(busy2), 32'(mbusy[chk_addr2] && chk_addr2 != 5'd0));
    end
  end

  initial begin
    n_pass = 0; n_total = 0; chk_en = 1'b0;
    mbusy = '0; lu_taken = 1'b1;
    resetn = 1'b0;
    rand_inputs();
    cycle();
    rand_inputs();
    cycle();

    // Reset state
    resetn = 1'b1;
    idle_inputs();
    chk_en = 1'b1;
    #1;
    check("rst_buf_cnt", 32'(buf_cnt), 32'd0);
    check("rst_lu_ready", 32'(lu_ready), 32'd1);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    for (int a = 0; a < 32; a++) begin
      chk_addr1 = 5'(a); chk_addr2 = 5'(31 - a);
      #1;
      check("rst_busy1", 32'(busy1), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);
      cycle();
    end

    // Issue to r5 then its result at an idle pipeline
    lu_issue_valid = 1'b1; lu_issue_addr = 5'd5; chk_addr1 = 5'd5;
    cycle();
    lu_issue_valid = 1'b0;
    lu_valid = 1'b1; lu_we = 4'hF; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
    #1;
    check("r5_busy_before", 32'(busy1), 32'd1);
`ifdef RF_ARB_BYPASS_EN
    check("r5_byp_waddr", 32'(rf_waddr), 32'd5);
    check("r5_byp_wdata", rf_wdata, 32'hDEADBEEF);
`else
    check("r5_no_early_we", 32'(rf_we), 32'd0);
`endif
    cycle();
    lu_valid = 1'b0;
    #1;
`ifdef RF_ARB_BYPASS_EN
    check("r5_busy_cleared", 32'(busy1), 32'd0);
`else
    check("r5_we", 32'(rf_we), 32'hF);
    check("r5_waddr", 32'(rf_waddr), 32'd5);
    check("r5_wdata", rf_wdata, 32'hDEADBEEF);
    check("r5_busy_until_write", 32'(busy1), 32'd1);
`endif
    cycle();
    #1;
    check("r5_busy_after", 32'(busy1), 32'd0);

    // Pipeline stream fills the FIFO; third result is held; in-order drain
    pipe_we = 4'hF; pipe_waddr = 5'd1; pipe_wdata = 32'h11111111;
    lu_valid = 1'b1; lu_we = 4'hF; lu_waddr = 5'd10; lu_wdata = 32'hA1;
    #1;
    check("full_pipe_prio", 32'(rf_waddr), 32'd1);
    cycle();
    lu_waddr = 5'd11; lu_wdata = 32'hA2;
    #1;
    check("full_cnt1", 32'(buf_cnt), 32'd1);
    cycle();
    lu_waddr = 5'd12; lu_wdata = 32'hA3;
    #1;
    check("full_cnt2", 32'(buf_cnt), 32'd2);
    check("full_not_ready", 32'(lu_ready), 32'd0);
    cycle();
    #1;
    check("full_held_cnt", 32'(buf_cnt), 32'd2);
    cycle();
    pipe_we = 4'd0;
    #1;
    check("drain0_waddr", 32'(rf_waddr), 32'd10);
    check("drain0_wdata", rf_wdata, 32'hA1);
    cycle();
    #1;
    check("drain1_waddr", 32'(rf_waddr), 32'd11);
    check("drain1_ready", 32'(lu_ready), 32'd1);
    cycle();
    lu_valid = 1'b0;
    #1;
    check("drain2_waddr", 32'(rf_waddr), 32'd12);
    check("drain2_wdata", rf_wdata, 32'hA3);
    check("drain2_cnt", 32'(buf_cnt), 32'd1);
    cycle();
    #1;
    check("drained_cnt", 32'(buf_cnt), 32'd0);
    check("drained_we", 32'(rf_we), 32'd0);

    // Drain of r7 coinciding with a new issue to r7
    lu_issue_valid = 1'b1; lu_issue_addr = 5'd7;
    cycle();
    lu_issue_valid = 1'b0;
    pipe_we = 4'h3; pipe_waddr = 5'd2;
    lu_valid = 1'b1; lu_we = 4'hF; lu_waddr = 5'd7; lu_wdata = 32'h77;
    cycle();
    pipe_we = 4'd0; lu_valid = 1'b0;
    lu_issue_valid = 1'b1; lu_issue_addr = 5'd7; chk_addr1 = 5'd7;
    #1;
    check("r7_drain_waddr", 32'(rf_waddr), 32'd7);
    cycle();
    lu_issue_valid = 1'b0;
    #1;
    check("r7_set_wins", 32'(busy1), 32'd1);

    // Partial byte enables pass through; issue to r0 never marks busy
    pipe_we = 4'h1;
    lu_valid = 1'b1; lu_we = 4'b0010; lu_waddr = 5'd3; lu_wdata = 32'h12345678;
    cycle();
    pipe_we = 4'd0; lu_valid = 1'b0;
    lu_issue_valid = 1'b1; lu_issue_addr = 5'd0; chk_addr1 = 5'd0;
    #1;
    check("be_we", 32'(rf_we), 32'h2);
    check("be_waddr", 32'(rf_waddr), 32'd3);
    check("be_wdata", rf_wdata, 32'h12345678);
    cycle();
    lu_issue_valid = 1'b0;
    #1;
    check("r0_never_busy", 32'(busy1), 32'd0);

    // Reset with a full FIFO discards entries and busy bits
    lu_issue_valid = 1'b1; lu_issue_addr = 5'd20; chk_addr1 = 5'd20;
    cycle();
    lu_issue_valid = 1'b0;
    pipe_we = 4'hF;
    lu_valid = 1'b1; lu_we = 4'hF; lu_waddr = 5'd20; lu_wdata = 32'h20;
    cycle();
    lu_waddr = 5'd21; lu_wdata = 32'h21;
    cycle();
    lu_valid = 1'b0;
    #1;
    check("prerst_cnt", 32'(buf_cnt), 32'd2);
    check("prerst_busy", 32'(busy1), 32'd1);
    resetn = 1'b0; pipe_we = 4'd0;
    cycle();
    resetn = 1'b1;
    #1;
    check("postrst_cnt", 32'(buf_cnt), 32'd0);
    check("postrst_we", 32'(rf_we), 32'd0);
    check("postrst_busy", 32'(busy1), 32'd0);
    check("postrst_ready", 32'(lu_ready), 32'd1);
    cycle();
    #1;
    check("postrst_we2", 32'(rf_we), 32'd0);

    // Randomized traffic respecting upstream guarantees
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 1) != 0) pipe_we = 4'($urandom_range(1, 15));
      else pipe_we = 4'd0;
      pipe_waddr = 5'($urandom);
      if (mbusy[pipe_waddr]) pipe_waddr = 5'd0;
      pipe_wdata = $urandom;
      lu_issue_addr = 5'($urandom);
      lu_issue_valid = ($urandom_range(0, 3) == 0) && !mbusy[lu_issue_addr];
      if (lu_taken) begin
        lu_valid = ($urandom_range(0, 99) < 45);
        lu_we = 4'($urandom);
        lu_waddr = 5'($urandom);
        lu_wdata = $urandom;
      end
      chk_addr1 = 5'($urandom);
      chk_addr2 = 5'($urandom);
      cycle();
    end

    resetn = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
